// File: rtl/imem_loader.sv
// Byte-stream program loader: frames of A5, LEN (LE16), LEN little-endian words and an XOR checksum
// are written into instruction memory while the CPU is held halted.
module imem_loader #(
   parameter int ADDR_W         = 13,
   parameter int MEM_WORDS      = 8192,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_halt,
   output logic              cpu_restart,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       words_loaded
);

   localparam int         TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERROR
   } state_t;

   state_t              state_reg, state_next;
   logic [15:0]         len_reg, len_next;
   logic [7:0]          cks_reg, cks_next;
   logic [23:0]         word_reg, word_next;
   logic [1:0]          byte_idx_reg, byte_idx_next;
   logic [TMO_W-1:0]    tmo_reg, tmo_next;
   logic [15:0]         words_loaded_reg, words_loaded_next;
   logic                mem_we_reg, mem_we_next;
   logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
   logic [31:0]         mem_wdata_reg, mem_wdata_next;
   logic                halt_reg, halt_next;
   logic                err_reg, err_next;

   logic                hs;
   logic                active;
   logic [15:0]         len_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         len_reg          <= '0;
         cks_reg          <= '0;
         word_reg         <= '0;
         byte_idx_reg     <= '0;
         tmo_reg          <= '0;
         words_loaded_reg <= '0;
         mem_we_reg       <= 1'b0;
         mem_addr_reg     <= '0;
         mem_wdata_reg    <= '0;
         halt_reg         <= 1'b0;
         err_reg          <= 1'b0;
      end else begin
         state_reg        <= state_next;
         len_reg          <= len_next;
         cks_reg          <= cks_next;
         word_reg         <= word_next;
         byte_idx_reg     <= byte_idx_next;
         tmo_reg          <= tmo_next;
         words_loaded_reg <= words_loaded_next;
         mem_we_reg       <= mem_we_next;
         mem_addr_reg     <= mem_addr_next;
         mem_wdata_reg    <= mem_wdata_next;
         halt_reg         <= halt_next;
         err_reg          <= err_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      len_next          = len_reg;
      cks_next          = cks_reg;
      word_next         = word_reg;
      byte_idx_next     = byte_idx_reg;
      tmo_next          = '0;
      mem_we_next       = 1'b0;
      mem_addr_next     = mem_addr_reg;
      mem_wdata_next    = mem_wdata_reg;
      halt_next         = halt_reg;
      err_next          = err_reg;
      rx_ready          = (state_reg != DONE);
      hs                = rx_valid && rx_ready;
      active            = (state_reg == LEN0) || (state_reg == LEN1) ||
                          (state_reg == DATA) || (state_reg == CHECK);
      len_full          = {rx_data, len_reg[7:0]};
      // The word counter advances in the cycle its write strobe is on the bus.
      words_loaded_next = words_loaded_reg + (mem_we_reg ? 16'd1 : 16'd0);

      case (state_reg)
         IDLE, ERROR: begin
            if (hs && rx_data == MAGIC) begin
               cks_next          = '0;
               words_loaded_next = '0;
               byte_idx_next     = '0;
               err_next          = 1'b0;
               halt_next         = 1'b1;
               state_next        = LEN0;
            end
         end
         LEN0: begin
            if (hs) begin
               len_next[7:0] = rx_data;
               cks_next      = cks_reg ^ rx_data;
               state_next    = LEN1;
            end
         end
         LEN1: begin
            if (hs) begin
               len_next[15:8] = rx_data;
               cks_next       = cks_reg ^ rx_data;
               byte_idx_next  = '0;
               if (len_full == 16'd0) begin
                  state_next = CHECK;
               end else if ({1'b0, len_full} > 17'(MEM_WORDS)) begin
                  err_next   = 1'b1;
                  state_next = ERROR;
               end else begin
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            if (hs) begin
               cks_next      = cks_reg ^ rx_data;
               word_next     = {rx_data, word_reg[23:8]};
               byte_idx_next = byte_idx_reg + 2'd1;
               if (byte_idx_reg == 2'd3) begin
                  mem_we_next    = 1'b1;
                  mem_addr_next  = words_loaded_reg[ADDR_W-1:0];
                  mem_wdata_next = {rx_data, word_reg};
                  if (words_loaded_reg + 16'd1 == len_reg)
                     state_next = CHECK;
               end
            end
         end
         CHECK: begin
            if (hs) begin
               if (rx_data == cks_reg) begin
                  state_next = DONE;
               end else begin
                  err_next   = 1'b1;
                  state_next = ERROR;
               end
            end
         end
         DONE: begin
            halt_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // An accepted byte always beats an expiring timeout.
      if (active) begin
         if (hs) begin
            tmo_next = '0;
         end else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            err_next   = 1'b1;
            state_next = ERROR;
         end else begin
            tmo_next = tmo_reg + TMO_W'(1);
         end
      end
   end

   assign mem_we       = mem_we_reg;
   assign mem_addr     = mem_addr_reg;
   assign mem_wdata    = mem_wdata_reg;
   assign cpu_halt     = halt_reg;
   assign load_err     = err_reg;
   assign words_loaded = words_loaded_reg;
   assign load_done    = (state_reg == DONE);
   assign cpu_restart  = (state_reg == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, oversize length, empty frame, timeout, mid-frame reset.
`timescale 1ns/1ps
module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_we;
   logic [12:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_halt;
   logic        cpu_restart;
   logic        load_done;
   logic        load_err;
   logic [15:0] words_loaded;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int done_count = 0;
   int restart_count = 0;
   logic [12:0] wr_addr_log [64];
   logic [31:0] wr_data_log [64];
   logic [31:0] mem_model [8192];

   imem_loader #(.ADDR_W(13), .MEM_WORDS(8192), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_halt(cpu_halt),
      .cpu_restart(cpu_restart), .load_done(load_done), .load_err(load_err),
      .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory side: record every write the loader issues.
   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         if (wr_count < 64) begin
            wr_addr_log[wr_count] = mem_addr;
            wr_data_log[wr_count] = mem_wdata;
         end
         mem_model[mem_addr] = mem_wdata;
         wr_count++;
      end
      if (load_done === 1'b1) done_count++;
      if (cpu_restart === 1'b1) restart_count++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      waited   = 0;
      while (rx_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (rx_ready !== 1'b1) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   int base;

   initial begin
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_cpu_halt", {31'd0, cpu_halt}, 32'd0);
      check("rst_load_err", {31'd0, load_err}, 32'd0);
      check("rst_load_done", {31'd0, load_done}, 32'd0);
      check("rst_words", {16'd0, words_loaded}, 32'd0);

      // Test 1: single word; checksum = 01^00^78^56^34^12 = 09.
      send_byte(8'hA5);
      check("t1_halt_after_magic", {31'd0, cpu_halt}, 32'd1);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      check("t1_halt_in_data", {31'd0, cpu_halt}, 32'd1);
      send_byte(8'h09);
      check("t1_load_done", {31'd0, load_done}, 32'd1);
      check("t1_cpu_restart", {31'd0, cpu_restart}, 32'd1);
      check("t1_rx_ready_done", {31'd0, rx_ready}, 32'd0);
      @(posedge clk); #1;
      check("t1_done_pulse_end", {31'd0, load_done}, 32'd0);
      check("t1_halt_released", {31'd0, cpu_halt}, 32'd0);
      check("t1_wr_count", wr_count, 32'd1);
      check("t1_wr_addr", {19'd0, wr_addr_log[0]}, 32'd0);
      check("t1_wr_data", wr_data_log[0], 32'h12345678);
      check("t1_done_count", done_count, 32'd1);
      check("t1_restart_count", restart_count, 32'd1);
      check("t1_words", {16'd0, words_loaded}, 32'd1);

      // Test 2: two words, wrong checksum (correct would be 0A).
      base = wr_count;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      send_byte(8'hFF);
      @(posedge clk); #1;
      check("t2_wr_count", wr_count - base, 32'd2);
      check("t2_wr0_addr", {19'd0, wr_addr_log[base]}, 32'd0);
      check("t2_wr0_data", wr_data_log[base], 32'h04030201);
      check("t2_wr1_addr", {19'd0, wr_addr_log[base+1]}, 32'd1);
      check("t2_wr1_data", wr_data_log[base+1], 32'h08070605);
      check("t2_load_err", {31'd0, load_err}, 32'd1);
      check("t2_halt_held", {31'd0, cpu_halt}, 32'd1);
      check("t2_no_done", done_count, 32'd1);
      check("t2_words", {16'd0, words_loaded}, 32'd2);
      // Recovery frame: checksum = 01^AA^BB^CC^DD = 01.
      send_byte(8'hA5);
      check("t2_err_cleared", {31'd0, load_err}, 32'd0);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      send_byte(8'h01);
      check("t2_recover_done", {31'd0, load_done}, 32'd1);
      check("t2_recover_data", wr_data_log[wr_count-1], 32'hDDCCBBAA);

      // Test 3: LEN = 0x2101 exceeds capacity; trailing bytes ignored.
      base = wr_count;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h21);
      check("t3_load_err", {31'd0, load_err}, 32'd1);
      check("t3_halt", {31'd0, cpu_halt}, 32'd1);
      send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
      check("t3_no_writes", wr_count - base, 32'd0);
      check("t3_err_sticky", {31'd0, load_err}, 32'd1);
      check("t3_words", {16'd0, words_loaded}, 32'd0);

      // Test 4: empty frame from the error state.
      base = wr_count;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("t4_load_done", {31'd0, load_done}, 32'd1);
      check("t4_err_clear", {31'd0, load_err}, 32'd0);
      @(posedge clk); #1;
      check("t4_no_writes", wr_count - base, 32'd0);
      check("t4_words", {16'd0, words_loaded}, 32'd0);
      check("t4_halt_released", {31'd0, cpu_halt}, 32'd0);

      // Test 5: timeout of 16 idle cycles.
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
      repeat (15) @(posedge clk);
      send_byte(8'h22);
      check("t5_byte_wins", {31'd0, load_err}, 32'd0);
      repeat (15) @(posedge clk);
      #1;
      check("t5_not_yet", {31'd0, load_err}, 32'd0);
      @(posedge clk); #1;
      check("t5_timeout_err", {31'd0, load_err}, 32'd1);
      check("t5_halt_held", {31'd0, cpu_halt}, 32'd1);

      // Test 6: reset after the second of four words.
      base = wr_count;
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
      for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
      @(posedge clk); #1;
      check("t6_pre_reset_writes", wr_count - base, 32'd2);
      reset = 1'b1;
      #1;
      check("t6_halt", {31'd0, cpu_halt}, 32'd0);
      check("t6_mem_we", {31'd0, mem_we}, 32'd0);
      check("t6_words", {16'd0, words_loaded}, 32'd0);
      check("t6_load_err", {31'd0, load_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check("t6_mem0", mem_model[0], 32'h14131211);
      check("t6_mem1", mem_model[1], 32'h18171615);
      send_byte(8'h55);
      check("t6_idle_ignores", {31'd0, cpu_halt}, 32'd0);
      check("t6_rx_ready", {31'd0, rx_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
